i2s_timing_gen: RTL

I2S_TIMING_GEN -- requirements
Module: i2s_timing_gen

---
 rtl/i2s_pkg.sv | 14 +
 rtl/i2s_bclk_div.sv | 55 +++++
 rtl/i2s_timing_gen.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// Shared constants for the I2S timing generator: format codes and FSM encoding.
package i2s_pkg;

   localparam int FMT_I2S = 0;
   localparam int FMT_LJ  = 1;
   localparam int FMT_TDM = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

endpackage

// File: rtl/i2s_bclk_div.sv
// Half-period counter producing the bit clock and its rise/fall strobes.
// fall_evt_o flags the edge that will drop bclk, so the parent can update
// its counters in the same cycle the fall strobe becomes visible.
module i2s_bclk_div #(
   parameter int DIV_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             run_i,
   input  logic             stop_i,
   input  logic [DIV_W-1:0] div_i,
   output logic             bclk_o,
   output logic             rise_stb_o,
   output logic             fall_stb_o,
   output logic             fall_evt_o
);

   logic [DIV_W-1:0] cnt_q;
   logic             bclk_q;
   logic             rise_q;
   logic             fall_q;
   logic             wrap;

   assign wrap       = run_i && (cnt_q == div_i);
   assign fall_evt_o = wrap && bclk_q;

   // Count 0..div, toggle bclk on wrap; held at zero while not running or stopping.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q  <= '0;
         bclk_q <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else if (!run_i || stop_i) begin
         cnt_q  <= '0;
         bclk_q <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         rise_q <= wrap && !bclk_q;
         fall_q <= wrap && bclk_q;
         if (wrap) begin
            cnt_q  <= '0;
            bclk_q <= ~bclk_q;
         end else begin
            cnt_q  <= cnt_q + DIV_W'(1);
         end
      end
   end

   assign bclk_o     = bclk_q;
   assign rise_stb_o = rise_q;
   assign fall_stb_o = fall_q;

endmodule

// File: rtl/i2s_timing_gen.sv
// I2S / left-justified / TDM timing generator: run/drain FSM, bit and slot
// counters and word-select shaping around the bclk divider.
module i2s_timing_gen
   import i2s_pkg::*;
#(
   parameter int DIV_W  = 8,
   parameter int SLOT_W = 32,
   parameter int SLOTS  = 2,
   parameter int FMT    = 0
) (
   input  logic                                          clk_in,
   input  logic                                          reset,
   input  logic                                          enable,
   input  logic [DIV_W-1:0]                              div_half,
   output logic                                          i2s_clk,
   output logic                                          i2s_ws,
   output logic                                          bclk_rise_stb,
   output logic                                          bclk_fall_stb,
   output logic                                          frame_start,
   output logic [$clog2(SLOT_W)-1:0]                     bit_idx,
   output logic [((SLOTS > 2) ? $clog2(SLOTS) : 1)-1:0]  slot_idx,
   output logic                                          active
);

   localparam int BIT_W   = $clog2(SLOT_W);
   localparam int SLOT_IW = (SLOTS > 2) ? $clog2(SLOTS) : 1;
   localparam logic [BIT_W-1:0]   BIT_LAST  = BIT_W'(SLOT_W - 1);
   localparam logic [SLOT_IW-1:0] SLOT_LAST = SLOT_IW'(SLOTS - 1);

   state_e             state_q;
   logic               first_q;
   logic [BIT_W-1:0]   bit_q;
   logic [SLOT_IW-1:0] slot_q;
   logic               ws_q;
   logic               fs_q;
   logic [DIV_W-1:0]   div_q;
   logic               active_q;

   logic [BIT_W-1:0]   bit_d;
   logic [SLOT_IW-1:0] slot_d;
   logic               ws_d;
   logic               run;
   logic               fall_evt;
   logic               last_bit;
   logic               last_slot;
   logic               frame_bound;
   logic               stop;

   assign run       = (state_q != ST_IDLE);
   assign last_bit  = (bit_q == BIT_LAST);
   assign last_slot = (slot_q == SLOT_LAST);
   // The very first fall after start opens a frame just like the wrap does.
   assign frame_bound = first_q || (last_bit && last_slot);
   // Draining ends on the fall that would otherwise open the next frame.
   assign stop = (state_q == ST_DRAIN) && !enable && fall_evt && frame_bound;

   i2s_bclk_div #(.DIV_W(DIV_W)) u_bclk (
      .clk_i      (clk_in),
      .rst_i      (reset),
      .run_i      (run),
      .stop_i     (stop),
      .div_i      (div_q),
      .bclk_o     (i2s_clk),
      .rise_stb_o (bclk_rise_stb),
      .fall_stb_o (bclk_fall_stb),
      .fall_evt_o (fall_evt)
   );

   // Next bit/slot position and word-select level taken on the coming fall.
   always_comb begin
      bit_d  = bit_q;
      slot_d = slot_q;
      ws_d   = ws_q;
      if (first_q || last_bit) bit_d = '0;
      else                     bit_d = bit_q + BIT_W'(1);
      if (first_q)       slot_d = '0;
      else if (last_bit) slot_d = last_slot ? '0 : slot_q + SLOT_IW'(1);
      if (FMT == FMT_LJ) begin
         ws_d = slot_d[0];
      end else if (FMT == FMT_TDM) begin
         ws_d = (slot_d == SLOT_LAST) && (bit_d == BIT_LAST);
      end else begin
         // Philips: ws leads the slot by one bit.
         if (bit_d == BIT_LAST && slot_d == '0)                 ws_d = 1'b1;
         else if (bit_d == BIT_LAST && slot_d == SLOT_IW'(1))   ws_d = 1'b0;
      end
   end

   // Run/drain FSM with registered counters, ws, frame strobe and divider latch.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         first_q  <= 1'b0;
         bit_q    <= '0;
         slot_q   <= '0;
         ws_q     <= 1'b0;
         fs_q     <= 1'b0;
         div_q    <= '0;
         active_q <= 1'b0;
      end else begin
         fs_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (enable) begin
                  state_q  <= ST_RUN;
                  div_q    <= div_half;
                  first_q  <= 1'b1;
                  bit_q    <= '0;
                  slot_q   <= '0;
                  ws_q     <= 1'b0;
                  active_q <= 1'b1;
               end
            end
            ST_RUN, ST_DRAIN: begin
               if (stop) begin
                  state_q  <= ST_IDLE;
                  first_q  <= 1'b0;
                  bit_q    <= '0;
                  slot_q   <= '0;
                  ws_q     <= 1'b0;
                  active_q <= 1'b0;
               end else begin
                  state_q <= enable ? ST_RUN : ST_DRAIN;
                  if (fall_evt) begin
                     bit_q   <= bit_d;
                     slot_q  <= slot_d;
                     ws_q    <= ws_d;
                     first_q <= 1'b0;
                     fs_q    <= frame_bound;
                     // Divider only changes on a frame boundary.
                     if (frame_bound) div_q <= div_half;
                  end
               end
            end
            default: begin
               state_q  <= ST_IDLE;
               active_q <= 1'b0;
            end
         endcase
      end
   end

   assign i2s_ws      = ws_q;
   assign frame_start = fs_q;
   assign bit_idx     = bit_q;
   assign slot_idx    = slot_q;
   assign active      = active_q;

endmodule
